hamm_dec: RTL and testbench

HAMM_DEC -- requirements
Module: hamm_dec

---
 rtl/hamm_dec_pkg.sv | 29 ++
 rtl/hamm_syndrome.sv | 17 +
 rtl/hamm_dec.sv | 126 ++++++++++++
 tb/tb_hamm_dec.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamm_dec_pkg.sv
// Shared definitions for the (12,8) SECDED Hamming decoder: widths, status codes and
// the codeword-bit-to-data-bit map.
package hamm_dec_pkg;

  localparam int unsigned CwW   = 12;
  localparam int unsigned DataW = 8;
  localparam int unsigned SynW  = 4;

  typedef enum logic [1:0] {
    ErrNone   = 2'b00,
    ErrCorr   = 2'b01,
    ErrUncorr = 2'b10
  } err_e;

  // Codeword bit index holding data bit i (Hamming positions 3,5,6,7,9,10,11,12).
  localparam logic [DataW-1:0][3:0] DataIdx = {
    4'd11, 4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2
  };

  function automatic logic [DataW-1:0] extract_data(input logic [CwW-1:0] cw);
    logic [DataW-1:0] d;
    d = '0;
    for (int i = 0; i < DataW; i++) begin
      d[i] = cw[DataIdx[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamm_syndrome.sv
// Combinational syndrome and overall-parity check for a 12-bit Hamming codeword.
module hamm_syndrome
  import hamm_dec_pkg::*;
(
  input  logic [CwW-1:0]  cw_i,
  input  logic            parity_i,
  output logic [SynW-1:0] syn_o,
  output logic            q_o
);

  assign syn_o[0] = cw_i[0] ^ cw_i[2] ^ cw_i[4] ^ cw_i[6] ^ cw_i[8] ^ cw_i[10];
  assign syn_o[1] = cw_i[1] ^ cw_i[2] ^ cw_i[5] ^ cw_i[6] ^ cw_i[9] ^ cw_i[10];
  assign syn_o[2] = cw_i[3] ^ cw_i[4] ^ cw_i[5] ^ cw_i[6] ^ cw_i[11];
  assign syn_o[3] = cw_i[7] ^ cw_i[8] ^ cw_i[9] ^ cw_i[10] ^ cw_i[11];
  assign q_o      = (^cw_i) ^ parity_i;

endmodule

// File: rtl/hamm_dec.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready handshake and
// saturating corrected/uncorrectable event counters.
module hamm_dec
  import hamm_dec_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [CwW-1:0]   hamm_in_i,
  input  logic             in_parity_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DataW-1:0] data_out_o,
  output logic [1:0]       err_status_o,
  output logic [SynW-1:0]  syndrome_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] uncorr_cnt_o
);

  logic             v1_q, q1_q;
  logic [CwW-1:0]   cw1_q;
  logic [SynW-1:0]  syn1_q;
  logic             v2_q;
  logic [DataW-1:0] data2_q;
  err_e             st2_q;
  logic [SynW-1:0]  syn2_q;
  logic [CNT_W-1:0] corr_q, corr_d, uncorr_q, uncorr_d;

  logic [SynW-1:0]  syn_in;
  logic             q_in;
  logic             adv, ld1, xfer;
  logic [CwW-1:0]   cw_fix;
  err_e             st_d;

  hamm_syndrome u_syndrome (
    .cw_i     (hamm_in_i),
    .parity_i (in_parity_i),
    .syn_o    (syn_in),
    .q_o      (q_in)
  );

  // Stage 1 may also fill while stage 2 is stalled, as long as stage 1 itself is empty.
  assign adv        = !v2_q || out_ready_i;
  assign ld1        = adv || !v1_q;
  assign in_ready_o = ld1;
  assign xfer       = v2_q && out_ready_i;

  always_comb begin
    cw_fix = cw1_q;
    st_d   = ErrNone;
    if (syn1_q == '0) begin
      st_d = q1_q ? ErrCorr : ErrNone;
    end else if (!q1_q) begin
      st_d = ErrUncorr;
    end else if (syn1_q <= 4'd12) begin
      for (int i = 0; i < CwW; i++) begin
        if (syn1_q == 4'(i + 1)) cw_fix[i] = ~cw1_q[i];
      end
      st_d = ErrCorr;
    end else begin
      st_d = ErrUncorr;
    end
  end

  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (cnt_clr_i) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (xfer) begin
      if (st2_q == ErrCorr && corr_q != '1) begin
        corr_d = corr_q + {{(CNT_W - 1){1'b0}}, 1'b1};
      end
      if (st2_q == ErrUncorr && uncorr_q != '1) begin
        uncorr_d = uncorr_q + {{(CNT_W - 1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q     <= 1'b0;
      cw1_q    <= '0;
      syn1_q   <= '0;
      q1_q     <= 1'b0;
      v2_q     <= 1'b0;
      data2_q  <= '0;
      st2_q    <= ErrNone;
      syn2_q   <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      if (ld1) begin
        v1_q <= in_valid_i;
        if (in_valid_i) begin
          cw1_q  <= hamm_in_i;
          syn1_q <= syn_in;
          q1_q   <= q_in;
        end
      end
      if (adv) begin
        v2_q <= v1_q;
        if (v1_q) begin
          data2_q <= extract_data(cw_fix);
          st2_q   <= st_d;
          syn2_q  <= syn1_q;
        end
      end
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign out_valid_o  = v2_q;
  assign data_out_o   = data2_q;
  assign err_status_o = st2_q;
  assign syndrome_o   = syn2_q;
  assign corr_cnt_o   = corr_q;
  assign uncorr_cnt_o = uncorr_q;

endmodule

// File: tb/tb_hamm_dec.sv
// Directed self-checking bench for hamm_dec; a second instance with 2-bit counters
// shares the stimulus to exercise saturation.
module tb_hamm_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, in_parity, cnt_clr;
  logic [11:0] hamm_in;

  logic        in_ready, out_valid;
  logic [7:0]  data_out;
  logic [1:0]  err;
  logic [3:0]  syn;
  logic [15:0] corr, uncorr;

  logic        in_ready_s, out_valid_s;
  logic [7:0]  data_s;
  logic [1:0]  err_s;
  logic [3:0]  syn_s;
  logic [1:0]  corr_s, uncorr_s;

  int n_checks = 0;
  int n_errors = 0;
  int exp_corr = 0;
  int exp_uncorr = 0;

  always #5 clk = ~clk;

  hamm_dec #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .hamm_in_i(hamm_in), .in_parity_i(in_parity), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .data_out_o(data_out), .err_status_o(err),
    .syndrome_o(syn), .cnt_clr_i(cnt_clr), .corr_cnt_o(corr), .uncorr_cnt_o(uncorr)
  );

  hamm_dec #(.CNT_W(2)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
    .hamm_in_i(hamm_in), .in_parity_i(in_parity), .out_valid_o(out_valid_s),
    .out_ready_i(out_ready), .data_out_o(data_s), .err_status_o(err_s),
    .syndrome_o(syn_s), .cnt_clr_i(cnt_clr), .corr_cnt_o(corr_s), .uncorr_cnt_o(uncorr_s)
  );

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Called #1 after a rising edge with the pipeline empty.
  task automatic send_one(input logic [11:0] cw, input logic par, input logic [7:0] ed,
                          input logic [1:0] est, input logic [3:0] esyn, input logic clr,
                          input string name);
    int waited;
    hamm_in = cw; in_parity = par; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 2) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s out_valid timeout: got %b want 1", name, out_valid);
    end else if ({data_out, err, syn} !== {ed, est, esyn}) begin
      n_errors++;
      $display("FAIL %s result: got data=%h st=%b syn=%0d want data=%h st=%b syn=%0d",
               name, data_out, err, syn, ed, est, esyn);
    end
    cnt_clr = clr;
    if (clr) begin
      exp_corr = 0; exp_uncorr = 0;
    end else if (est == 2'b01) exp_corr++;
    else if (est == 2'b10) exp_uncorr++;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || corr !== 16'(exp_corr) || uncorr !== 16'(exp_uncorr) ||
        corr_s !== 2'(sat3(exp_corr)) || uncorr_s !== 2'(sat3(exp_uncorr))) begin
      n_errors++;
      $display("FAIL %s counters: got ov=%b corr=%0d uncorr=%0d corr2=%0d uncorr2=%0d want ov=0 %0d %0d %0d %0d",
               name, out_valid, corr, uncorr, corr_s, uncorr_s, exp_corr, exp_uncorr,
               sat3(exp_corr), sat3(exp_uncorr));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_parity = 1'b0;
    cnt_clr = 1'b0; hamm_in = '0;
    #3;
    n_checks++;
    if ({out_valid, data_out, err, syn} !== 15'd0 || corr !== 16'd0 || uncorr !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got ov=%b data=%h st=%b syn=%0d corr=%0d uncorr=%0d want all 0",
               out_valid, data_out, err, syn, corr, uncorr);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got in_ready=%b ov=%b want 1 0", in_ready, out_valid);
    end
    exp_corr = 0; exp_uncorr = 0;
  endtask

  task automatic test_clean();
    send_one(12'hA27, 1'b0, 8'hA5, 2'b00, 4'd0, 1'b0, "clean_a5");
    send_one(12'hF77, 1'b0, 8'hFF, 2'b00, 4'd0, 1'b0, "clean_ff");
  endtask

  task automatic test_single();
    send_one(12'hA37, 1'b0, 8'hA5, 2'b01, 4'd5,  1'b0, "single_pos5");
    send_one(12'h227, 1'b0, 8'hA5, 2'b01, 4'd12, 1'b0, "single_pos12");
    send_one(12'hAA7, 1'b0, 8'hA5, 2'b01, 4'd8,  1'b0, "single_pos8");
    send_one(12'h040, 1'b0, 8'h00, 2'b01, 4'd7,  1'b0, "single_pos7");
  endtask

  task automatic test_parity_bit();
    send_one(12'hA27, 1'b1, 8'hA5, 2'b01, 4'd0, 1'b0, "parity_only");
  endtask

  task automatic test_double();
    send_one(12'hA24, 1'b0, 8'hA5, 2'b10, 4'd3, 1'b0, "double_pos1_2");
  endtask

  task automatic test_uncorr_high();
    send_one(12'hAAE, 1'b0, 8'hA5, 2'b10, 4'd13, 1'b0, "syn13_uncorr");
  endtask

  task automatic test_back_to_back();
    logic [11:0] cws [6];
    logic [13:0] exp [6];
    logic [13:0] held;
    logic stalled, saw_low;
    int sent, got;
    cws[0] = 12'hA27; exp[0] = {8'hA5, 2'b00, 4'd0};
    cws[1] = 12'hA37; exp[1] = {8'hA5, 2'b01, 4'd5};
    cws[2] = 12'h040; exp[2] = {8'h00, 2'b01, 4'd7};
    cws[3] = 12'hF77; exp[3] = {8'hFF, 2'b00, 4'd0};
    cws[4] = 12'hA24; exp[4] = {8'hA5, 2'b10, 4'd3};
    cws[5] = 12'h000; exp[5] = {8'h00, 2'b00, 4'd0};
    sent = 0; got = 0; stalled = 1'b0; saw_low = 1'b0; held = '0;
    in_parity = 1'b0;
    for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 6);
      if (sent < 6) hamm_in = cws[sent];
      #1;
      if (stalled) begin
        n_checks++;
        if ({data_out, err, syn} !== held) begin
          n_errors++;
          $display("FAIL b2b_stall_hold cyc%0d: got %h want %h", cyc, {data_out, err, syn}, held);
        end
      end
      if (in_valid && !in_ready) saw_low = 1'b1;
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          n_checks++;
          if ({data_out, err, syn} !== exp[got]) begin
            n_errors++;
            $display("FAIL b2b_word%0d: got %h want %h", got, {data_out, err, syn}, exp[got]);
          end
          if (exp[got][5:4] == 2'b01) exp_corr++;
          else if (exp[got][5:4] == 2'b10) exp_uncorr++;
          got++;
        end else begin
          stalled = 1'b1;
          held = {data_out, err, syn};
        end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got !== 6 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_delivered: got %0d words ov=%b want 6 ov=0", got, out_valid);
    end
    n_checks++;
    if (saw_low !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_in_ready_low: got %b want 1", saw_low);
    end
    n_checks++;
    if (corr !== 16'(exp_corr) || uncorr !== 16'(exp_uncorr)) begin
      n_errors++;
      $display("FAIL b2b_counters: got %0d %0d want %0d %0d", corr, uncorr, exp_corr, exp_uncorr);
    end
  endtask

  task automatic test_reset_mid();
    hamm_in = 12'hA37; in_parity = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, data_out, err, syn} !== 15'd0 || corr !== 16'd0 || uncorr !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_mid: got ov=%b data=%h st=%b syn=%0d corr=%0d uncorr=%0d want all 0",
               out_valid, data_out, err, syn, corr, uncorr);
    end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_flush: got ov=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    exp_corr = 0; exp_uncorr = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      send_one(12'hA37, 1'b0, 8'hA5, 2'b01, 4'd5, 1'b0, "sat_fill");
    end
    n_checks++;
    if (corr_s !== 2'd3 || corr !== 16'd5) begin
      n_errors++;
      $display("FAIL sat_cap: got corr2=%0d corr=%0d want 3 5", corr_s, corr);
    end
    send_one(12'hA37, 1'b0, 8'hA5, 2'b01, 4'd5, 1'b1, "clr_with_inc");
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_parity_bit();
    test_double();
    test_uncorr_high();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
